mul_unit: RTL and testbench

//  Multi-cycle RV32M multiply unit for the execute stage: MUL, MULH, MULHSU and MULHU.

---
 rtl/rv32i_types.sv | 20 ++
 rtl/wallace.sv | 61 ++++++
 rtl/mul_unit.sv | 115 +++++++++++
 tb/tb_mul_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types: multiply funct3 encodings and the multiply unit state.
package rv32i_types;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011
    } m_funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

endpackage

// File: rtl/wallace.sv
// Unsigned combinational Wallace-tree multiplier: 3:2 carry-save layers, one final carry-propagate add.
module wallace #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_p
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned LEVELS = WIDTH;

    logic [PW-1:0] w_rows [WIDTH];
    logic [PW-1:0] w_nxt  [WIDTH];
    int            w_n;
    int            w_m;
    int            w_full;
    int            w_rem;

    always_comb begin
        w_n    = WIDTH;
        w_m    = 0;
        w_full = 0;
        w_rem  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rows[i] = i_b[i] ? (PW'(i_a) << i) : '0;
            w_nxt[i]  = '0;
        end
        // Each layer compresses every full group of three rows into a sum and a shifted carry row.
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            if (w_n > 2) begin
                for (int i = 0; i < WIDTH; i++) begin
                    w_nxt[i] = '0;
                end
                w_full = w_n / 3;
                w_rem  = w_n - 3 * w_full;
                w_m    = 0;
                for (int g = 0; g < WIDTH / 3; g++) begin
                    if (g < w_full) begin
                        w_nxt[w_m]     = w_rows[3*g] ^ w_rows[3*g+1] ^ w_rows[3*g+2];
                        w_nxt[w_m + 1] = ((w_rows[3*g] & w_rows[3*g+1]) |
                                          (w_rows[3*g] & w_rows[3*g+2]) |
                                          (w_rows[3*g+1] & w_rows[3*g+2])) << 1;
                        w_m = w_m + 2;
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (k < w_rem) begin
                        w_nxt[w_m + k] = w_rows[3*w_full + k];
                    end
                end
                w_n = w_m + w_rem;
                for (int i = 0; i < WIDTH; i++) begin
                    w_rows[i] = w_nxt[i];
                end
            end
        end
        o_p = w_rows[0] + w_rows[1];
    end

endmodule

// File: rtl/mul_unit.sv
// RV32M multi-cycle multiplier: magnitude conversion on accept, registered Wallace product,
// two's-complement sign fix over the full product, then half-select with a one-cycle done.
module mul_unit
    import rv32i_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * WIDTH;

    mul_state_t       r_state;
    mul_state_t       w_next;
    m_funct3_t        r_op;
    logic             r_neg;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [PW-1:0]    r_prod;
    logic [WIDTH-1:0] r_result;

    m_funct3_t        w_op;
    logic             w_accept;
    logic             w_sa;
    logic             w_sb;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [PW-1:0]    w_prod;
    logic [PW-1:0]    w_fixed;

    // Operand signedness and magnitudes for the request presented this cycle.
    always_comb begin
        w_op     = m_funct3_t'({1'b0, funct3[1:0]});
        w_accept = start & ~funct3[2] & ~flush &
                   ((r_state == ST_IDLE) | (r_state == ST_DONE));
        w_sa     = (w_op != mulhu);
        w_sb     = (w_op == mul) | (w_op == mulh);
        w_neg_a  = w_sa & rs1[WIDTH-1];
        w_neg_b  = w_sb & rs2[WIDTH-1];
        w_mag_a  = w_neg_a ? (~rs1 + WIDTH'(1)) : rs1;
        w_mag_b  = w_neg_b ? (~rs2 + WIDTH'(1)) : rs2;
        w_fixed  = r_neg ? (~r_prod + PW'(1)) : r_prod;
    end

    wallace #(.WIDTH(WIDTH)) u_wallace (
        .i_a (r_mag_a),
        .i_b (r_mag_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and status outputs; flush overrides every transition.
    always_comb begin
        w_next = ST_IDLE;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_next = w_accept ? ST_CALC : ST_IDLE;
            ST_CALC:          w_next = ST_FIX;
            ST_FIX:           w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
        if (flush) begin
            w_next = ST_IDLE;
        end
        busy = (r_state == ST_CALC) | (r_state == ST_FIX);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= mul;
            r_neg    <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_neg   <= w_neg_a ^ w_neg_b;
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
            end
            if (r_state == ST_CALC) begin
                r_prod <= w_prod;
            end
            // A flushed op never reaches DONE, so the previous result must survive.
            if ((r_state == ST_FIX) && !flush) begin
                r_result <= (r_op == mul) ? w_fixed[WIDTH-1:0] : w_fixed[PW-1:WIDTH];
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_mul_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;
    logic [31:0] last_result;

    mul_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sign/zero-extend to 64 bits, multiply, pick the architectural half.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (f3 == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and check the busy/done timing and result at the fixed latency.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        tick();
        start = 1'b0; rs1 = $urandom; rs2 = $urandom;
        chk({tag, " busy c1"}, 32'(busy), 32'd1);
        chk({tag, " done c1"}, 32'(done), 32'd0);
        tick();
        chk({tag, " busy c2"}, 32'(busy), 32'd1);
        chk({tag, " done c2"}, 32'(done), 32'd0);
        tick();
        chk({tag, " done c3"}, 32'(done), 32'd1);
        chk({tag, " busy c3"}, 32'(busy), 32'd0);
        chk({tag, " result"}, result, exp);
        last_result = exp;
        tick();
        chk({tag, " done c4"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          seen_done;

        checks = 0; errors = 0; last_result = '0;
        rst = 1'b1; start = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0; flush = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed corner cases.
        run_op("mul 7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mul min*min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run_op("mulhsu -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul 0*min", 3'b000, 32'd0, 32'h8000_0000, 32'h0000_0000);
        run_op("mulhu 5*7", 3'b011, 32'd5, 32'd7, 32'h0000_0000);
        run_op("mul 12345*-6789", 3'b000, 32'd12345, 32'hFFFF_E57B, model(3'b000, 32'd12345, 32'hFFFF_E57B));

        // Flush while in CALC: op is dropped and the old result survives.
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
        tick();
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy next", 32'(busy), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) seen_done++;
            tick();
        end
        chk("flush no done", 32'(seen_done), 32'd0);
        chk("flush result kept", result, last_result);

        // Start and flush together: not accepted.
        start = 1'b1; flush = 1'b1; funct3 = 3'b001; rs1 = 32'd3; rs2 = 32'd4;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("start+flush busy", 32'(busy), 32'd0);

        // Async reset in FIX clears outputs without a clock edge.
        run_op("mul 100*200", 3'b000, 32'd100, 32'd200, 32'd20000);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd11; rs2 = 32'd13;
        tick();
        start = 1'b0;
        tick();
        chk("in fix busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst fix busy", 32'(busy), 32'd0);
        chk("rst fix done", 32'(done), 32'd0);
        chk("rst fix result", result, 32'd0);
        tick();
        rst = 1'b0;
        last_result = '0;
        tick();

        // Divide code is ignored.
        start = 1'b1; funct3 = 3'b100; rs1 = 32'd50; rs2 = 32'd5;
        tick();
        start = 1'b0;
        chk("div code busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        chk("div code no activity", 32'(seen_done), 32'd0);

        // Start while busy is dropped: only the first op completes.
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd6; rs2 = 32'd7;
        tick();
        funct3 = 3'b000; rs1 = 32'd1000; rs2 = 32'd1000;
        tick();
        start = 1'b0;
        tick();
        chk("busy start done", 32'(done), 32'd1);
        chk("busy start result", result, 32'd42);
        tick();
        chk("busy start no requeue", 32'(busy | done), 32'd0);
        tick();

        // Back-to-back: new start in the DONE cycle.
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd21; rs2 = 32'hFFFF_FFFE;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("b2b first done", 32'(done), 32'd1);
        chk("b2b first result", result, 32'hFFFF_FFD6);
        run_op("b2b mulhu 2x3", 3'b011, 32'd2, 32'd3, 32'd0);

        // Random ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (n % 10 == 0) a = 32'h8000_0000;
            if (n % 10 == 1) b = 32'hFFFF_FFFF;
            run_op("random", f3, a, b, model(f3, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
